one2two_demux: RTL and testbench

//  One-to-two registered demultiplexer. It is the splitting counterpart of the
//  bus two-to-one mux. One 8-bit producer stream comes in with a select bit;

---
 rtl/one2two_demux.sv | 143 ++++++++++++++
 tb/tb_one2two_demux.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/one2two_demux.sv
// One-to-two registered demultiplexer: steers an 8-bit stream to one of two
// per-port FIFOs so a stalled consumer only blocks bytes aimed at its own port.

module one2two_demux_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [AW:0]      cnt,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr_q;
    logic [AW-1:0]    wptr_q;
    logic [AW:0]      cnt_q;
    logic [WIDTH-1:0] data_q;

    logic             pop;
    logic [AW-1:0]    rptr_n;
    logic [AW-1:0]    wptr_n;
    logic [AW:0]      cnt_n;
    logic [AW:0]      remain;
    logic [WIDTH-1:0] data_n;

    assign valid = (cnt_q != '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign cnt   = cnt_q;
    assign data  = data_q;

    // Next pointers, occupancy and the head value that becomes visible next cycle
    always_comb begin
        pop    = valid && pop_ready;
        rptr_n = pop  ? rptr_q + AW'(1) : rptr_q;
        wptr_n = push ? wptr_q + AW'(1) : wptr_q;
        cnt_n  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        remain = cnt_q - (AW+1)'(pop);
        data_n = data_q;
        if (remain != '0) begin
            data_n = mem[rptr_n];
        end else if (push) begin
            data_n = wdata;
        end
    end

    // Storage, pointers and registered head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            if (push) begin
                mem[wptr_q] <= wdata;
            end
            rptr_q <= rptr_n;
            wptr_q <= wptr_n;
            cnt_q  <= cnt_n;
            data_q <= data_n;
        end
    end

endmodule

module one2two_demux #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [AW:0]      cnt0,
    output logic [AW:0]      cnt1
);

    logic run_q;
    logic full0;
    logic full1;
    logic push0;
    logic push1;

    // Holds in_ready low through reset and until the first edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Ready follows the selected port's registered fullness only
    always_comb begin
        in_ready = run_q && (in_sel ? !full1 : !full0);
        push0    = in_valid && in_ready && !in_sel;
        push1    = in_valid && in_ready &&  in_sel;
    end

    one2two_demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0),
        .wdata     (in_data),
        .pop_ready (out0_ready),
        .valid     (out0_valid),
        .data      (out0_data),
        .cnt       (cnt0),
        .full      (full0)
    );

    one2two_demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1),
        .wdata     (in_data),
        .pop_ready (out1_ready),
        .valid     (out1_valid),
        .data      (out1_data),
        .cnt       (cnt1),
        .full      (full1)
    );

endmodule

// File: tb/tb_one2two_demux.sv
// Scoreboard bench for one2two_demux: directed pushes queue expected bytes,
// a negedge monitor pops and compares on every output handshake.

module tb_one2two_demux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_sel;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out0_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] out1_data;
    logic [2:0] cnt0;
    logic [2:0] cnt1;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    one2two_demux dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic sel, input logic [7:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        chk("push_ready", int'(in_ready), 1);
        if (sel) q1.push_back(d);
        else     q0.push_back(d);
        tick();
        in_valid = 1'b0;
    endtask

    // Monitor: compare each output handshake against the scoreboard
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (out0_valid && out0_ready) begin
                    if (q0.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL port0_unexpected: got %0h expected none", out0_data);
                    end else begin
                        e = q0.pop_front();
                        chk("port0_data", int'(out0_data), int'(e));
                    end
                end
                if (out1_valid && out1_ready) begin
                    if (q1.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL port1_unexpected: got %0h expected none", out1_data);
                    end else begin
                        e = q1.pop_front();
                        chk("port1_data", int'(out1_data), int'(e));
                    end
                end
            end
        end
    end

    initial begin
        int mcnt;
        int sent;
        int cyc;
        logic pop_m;
        logic push_m;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = 1'b0;
        out0_ready = 1'b0; out1_ready = 1'b0;

        // 1 reset
        repeat (3) tick();
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_v0", int'(out0_valid), 0);
        chk("rst_v1", int'(out1_valid), 0);
        chk("rst_cnt0", int'(cnt0), 0);
        chk("rst_cnt1", int'(cnt1), 0);
        chk("rst_d0", int'(out0_data), 0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready_before_edge", int'(in_ready), 0);
        tick();
        chk("rel_ready_after_edge", int'(in_ready), 1);

        // 2 route
        out0_ready = 1'b1; out1_ready = 1'b1;
        push_byte(1'b0, 8'hA5);
        chk("route_v0", int'(out0_valid), 1);
        chk("route_d0", int'(out0_data), 8'hA5);
        chk("route_cnt0", int'(cnt0), 1);
        tick();
        chk("route_cnt0_drain", int'(cnt0), 0);
        push_byte(1'b1, 8'h3C);
        chk("route_v1", int'(out1_valid), 1);
        chk("route_d1", int'(out1_data), 8'h3C);
        tick();
        chk("route_cnt1_drain", int'(cnt1), 0);
        chk("route_v1_low", int'(out1_valid), 0);
        chk("route_d1_hold", int'(out1_data), 8'h3C);

        // 3 fill port 0, port 1 still open
        out0_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push_byte(1'b0, 8'(i));
        chk("fill_cnt0", int'(cnt0), 4);
        chk("fill_head", int'(out0_data), 8'h01);
        in_sel = 1'b0; #1;
        chk("fill_ready_sel0", int'(in_ready), 0);
        in_sel = 1'b1; #1;
        chk("fill_ready_sel1", int'(in_ready), 1);
        push_byte(1'b1, 8'hEE);
        chk("fill_d1", int'(out1_data), 8'hEE);
        chk("fill_cnt0_hold", int'(cnt0), 4);
        tick();
        chk("fill_cnt1", int'(cnt1), 0);

        // 4 drain port 0 in order
        out0_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_v0", int'(out0_valid), 1);
            chk("drain_d0", int'(out0_data), i);
            tick();
        end
        chk("drain_v0_low", int'(out0_valid), 0);
        chk("drain_d0_hold", int'(out0_data), 8'h04);

        // 5 stream 10 bytes to port 1 with toggling ready
        mcnt = 0; sent = 0; cyc = 0;
        out1_ready = 1'b0;
        while (sent < 10 && cyc < 200) begin
            in_valid = 1'b1; in_sel = 1'b1; in_data = 8'(8'h20 + sent);
            out1_ready = ~out1_ready;
            #1;
            chk("wrap_ready", int'(in_ready), (mcnt < 4) ? 1 : 0);
            push_m = (mcnt < 4);
            pop_m  = (mcnt > 0) && out1_ready;
            if (push_m) begin
                q1.push_back(in_data);
                sent++;
            end
            tick();
            mcnt = mcnt + int'(push_m) - int'(pop_m);
            chk("wrap_cnt1", int'(cnt1), mcnt);
            cyc++;
        end
        in_valid = 1'b0; out1_ready = 1'b1;
        cyc = 0;
        while (mcnt > 0 && cyc < 50) begin
            tick();
            mcnt--;
            cyc++;
        end
        chk("wrap_cnt1_end", int'(cnt1), 0);
        chk("wrap_q1_empty", q1.size(), 0);

        // 6 mid-op reset
        out0_ready = 1'b0; out1_ready = 1'b0;
        push_byte(1'b0, 8'hB0);
        push_byte(1'b1, 8'hC0);
        push_byte(1'b0, 8'hB1);
        push_byte(1'b1, 8'hC1);
        push_byte(1'b0, 8'hB2);
        chk("mid_cnt0", int'(cnt0), 3);
        chk("mid_cnt1", int'(cnt1), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_v0", int'(out0_valid), 0);
        chk("mid_v1", int'(out1_valid), 0);
        chk("mid_cnt0_clr", int'(cnt0), 0);
        chk("mid_cnt1_clr", int'(cnt1), 0);
        chk("mid_d0_clr", int'(out0_data), 0);
        chk("mid_d1_clr", int'(out1_data), 0);
        chk("mid_in_ready", int'(in_ready), 0);
        q0.delete(); q1.delete();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        out0_ready = 1'b1; out1_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("post_v0", int'(out0_valid), 0);
            chk("post_v1", int'(out1_valid), 0);
        end
        push_byte(1'b0, 8'hD0);
        chk("post_d0", int'(out0_data), 8'hD0);
        tick(); tick();
        chk("final_q0_empty", q0.size(), 0);
        chk("final_q1_empty", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
